// File: rtl/mdu_ctrl_if.sv
// E/D-stage handshake between the pipeline and the multiply/divide unit.
// The pipeline drives the master side and the MDU owns HI/LO behind the slave side.
interface mdu_ctrl_if;
    logic        Req;
    logic [3:0]  E_MDUOp;
    logic        E_Start;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_MDU_Use;
    logic [31:0] E_MDU_RES;
    logic        Busy;
    logic        Stall_MDU;

    modport master (
        output Req, E_MDUOp, E_Start, E_A, E_B, D_MDU_Use,
        input  E_MDU_RES, Busy, Stall_MDU
    );

    modport slave (
        input  Req, E_MDUOp, E_Start, E_A, E_B, D_MDU_Use,
        output E_MDU_RES, Busy, Stall_MDU
    );
endinterface

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide sequencer owning HI/LO. Results are computed at the start edge
// and committed after MULT_CYCLES/DIV_CYCLES busy cycles; D-stage MDU ops are stalled meanwhile.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       RESET,
    mdu_ctrl_if.slave  mdu_bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]   r_hi, w_hi_nxt;
    logic [31:0]   r_lo, w_lo_nxt;
    logic [31:0]   r_pend_hi, w_pend_hi_nxt;
    logic [31:0]   r_pend_lo, w_pend_lo_nxt;
    logic          r_pend_ok, w_pend_ok_nxt;

    logic          w_is_mul, w_is_div, w_is_mt, w_signed_div;
    logic [63:0]   w_prod_s, w_prod_u;
    logic [31:0]   w_a_mag, w_b_mag, w_dividend, w_divisor;
    logic [31:0]   w_uq, w_ur, w_quo, w_rem;

    assign w_is_mul     = (mdu_bus.E_MDUOp == OP_MULT) || (mdu_bus.E_MDUOp == OP_MULTU);
    assign w_is_div     = (mdu_bus.E_MDUOp == OP_DIV)  || (mdu_bus.E_MDUOp == OP_DIVU);
    assign w_is_mt      = (mdu_bus.E_MDUOp == OP_MTHI) || (mdu_bus.E_MDUOp == OP_MTLO);
    assign w_signed_div = (mdu_bus.E_MDUOp == OP_DIV);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{mdu_bus.E_A[31]}}, mdu_bus.E_A} * {{32{mdu_bus.E_B[31]}}, mdu_bus.E_B};
    assign w_prod_u = {32'd0, mdu_bus.E_A} * {32'd0, mdu_bus.E_B};

    // One unsigned divider on magnitudes; signs restored afterwards. A zero divisor is
    // replaced by 1 only to keep the datapath defined -- that result is never committed.
    assign w_a_mag    = mdu_bus.E_A[31] ? (32'd0 - mdu_bus.E_A) : mdu_bus.E_A;
    assign w_b_mag    = mdu_bus.E_B[31] ? (32'd0 - mdu_bus.E_B) : mdu_bus.E_B;
    assign w_dividend = w_signed_div ? w_a_mag : mdu_bus.E_A;
    assign w_divisor  = (mdu_bus.E_B == 32'd0) ? 32'd1 : (w_signed_div ? w_b_mag : mdu_bus.E_B);
    assign w_uq       = w_dividend / w_divisor;
    assign w_ur       = w_dividend % w_divisor;
    assign w_quo      = (w_signed_div && (mdu_bus.E_A[31] ^ mdu_bus.E_B[31])) ? (32'd0 - w_uq) : w_uq;
    assign w_rem      = (w_signed_div && mdu_bus.E_A[31]) ? (32'd0 - w_ur) : w_ur;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_ok_nxt = r_pend_ok;
        case (r_state)
            S_IDLE: begin
                if (!mdu_bus.Req) begin
                    if (mdu_bus.E_Start && w_is_mul) begin
                        w_state_nxt   = S_MUL;
                        w_cnt_nxt     = CW'(MULT_CYCLES);
                        w_pend_hi_nxt = (mdu_bus.E_MDUOp == OP_MULT) ? w_prod_s[63:32] : w_prod_u[63:32];
                        w_pend_lo_nxt = (mdu_bus.E_MDUOp == OP_MULT) ? w_prod_s[31:0]  : w_prod_u[31:0];
                        w_pend_ok_nxt = 1'b1;
                    end else if (mdu_bus.E_Start && w_is_div) begin
                        w_state_nxt   = S_DIV;
                        w_cnt_nxt     = CW'(DIV_CYCLES);
                        w_pend_hi_nxt = w_rem;
                        w_pend_lo_nxt = w_quo;
                        w_pend_ok_nxt = (mdu_bus.E_B != 32'd0);
                    end else if (mdu_bus.E_MDUOp == OP_MTHI) begin
                        w_hi_nxt = mdu_bus.E_A;
                    end else if (mdu_bus.E_MDUOp == OP_MTLO) begin
                        w_lo_nxt = mdu_bus.E_A;
                    end
                end
            end
            S_MUL, S_DIV: begin
                // Req is deliberately ignored here: the running op predates the fault.
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    if (r_pend_ok) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_ok <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_ok <= w_pend_ok_nxt;
        end
    end

    assign mdu_bus.Busy      = (r_state != S_IDLE);
    assign mdu_bus.Stall_MDU = mdu_bus.D_MDU_Use & (mdu_bus.Busy | mdu_bus.E_Start);
    assign mdu_bus.E_MDU_RES = (mdu_bus.E_MDUOp == OP_MFHI) ? r_hi :
                               (mdu_bus.E_MDUOp == OP_MFLO) ? r_lo : 32'd0;

    // The D-stage stall must keep any new MDU issue out of E while busy.
    a_no_issue_while_busy: assert property (@(posedge clk) disable iff (!RESET)
        !(mdu_bus.Busy && !mdu_bus.Req && (mdu_bus.E_Start || w_is_mt)));
endmodule
